// File: rtl/mutex_grant_gen.sv
// Two-requester mutual-exclusion grant generator.
// Alternates ownership on contention, caps each grant at MAX_HOLD cycles, and forces GAP_CYC idle
// cycles between any two grants. All outputs are registered.
module mutex_grant_gen #(
  parameter int unsigned MAX_HOLD = 8,  // legal 1..255
  parameter int unsigned GAP_CYC  = 1   // legal 1..15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  output logic a,
  output logic b,
  output logic busy,
  output logic timeout
);

  localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);
  localparam int unsigned GapW  = $clog2(GAP_CYC + 1);

  localparam logic [HoldW-1:0] HoldMax = HoldW'(MAX_HOLD);
  localparam logic [GapW-1:0]  GapMax  = GapW'(GAP_CYC);

  typedef enum logic [1:0] {
    StIdle,
    StOwnA,
    StOwnB,
    StGap
  } state_e;

  state_e           state_q, state_d, arb_state;
  logic [HoldW-1:0] hold_q;
  logic [GapW-1:0]  gap_q;
  logic             last_a_q;  // 1: A owned most recently, 0: B
  logic             timeout_d;
  logic             a_q, b_q, busy_q, timeout_q;

  // Arbitration used from IDLE and on the final GAP cycle; contention goes to the previous loser.
  always_comb begin
    arb_state = StIdle;
    if (req_a && req_b) begin
      arb_state = last_a_q ? StOwnB : StOwnA;
    end else if (req_a) begin
      arb_state = StOwnA;
    end else if (req_b) begin
      arb_state = StOwnB;
    end
  end

  // Next state; voluntary release takes priority over the hold-limit revoke.
  always_comb begin
    state_d   = state_q;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle: state_d = arb_state;
      StOwnA: begin
        if (!req_a) begin
          state_d = StGap;
        end else if (hold_q == HoldMax) begin
          state_d   = StGap;
          timeout_d = 1'b1;
        end
      end
      StOwnB: begin
        if (!req_b) begin
          state_d = StGap;
        end else if (hold_q == HoldMax) begin
          state_d   = StGap;
          timeout_d = 1'b1;
        end
      end
      StGap: begin
        if (gap_q == GapMax) begin
          state_d = arb_state;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state, hold/gap counters, last-owner flag and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      hold_q    <= '0;
      gap_q     <= '0;
      last_a_q  <= 1'b0;
      a_q       <= 1'b0;
      b_q       <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
      a_q       <= (state_d == StOwnA);
      b_q       <= (state_d == StOwnB);
      busy_q    <= (state_d != StIdle);

      // Ownership is never re-entered without passing through GAP, so a state change marks entry.
      if (state_d == StOwnA || state_d == StOwnB) begin
        hold_q <= (state_d != state_q) ? HoldW'(1) : hold_q + 1'b1;
      end else begin
        hold_q <= '0;
      end

      if (state_d == StGap) begin
        gap_q <= (state_q != StGap) ? GapW'(1) : gap_q + 1'b1;
      end else begin
        gap_q <= '0;
      end

      if (state_d == StOwnA && state_q != StOwnA) begin
        last_a_q <= 1'b1;
      end else if (state_d == StOwnB && state_q != StOwnB) begin
        last_a_q <= 1'b0;
      end
    end
  end

  assign a       = a_q;
  assign b       = b_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_mutex_grant_gen.sv
// Scoreboard bench for mutex_grant_gen: stimulus pushes expected {a,b,busy,timeout} per cycle,
// an independent monitor pops and compares just after each rising edge.
module tb_mutex_grant_gen;

  localparam logic [3:0] EIdle = 4'b0000;
  localparam logic [3:0] EA    = 4'b1010;
  localparam logic [3:0] EB    = 4'b0110;
  localparam logic [3:0] EGap  = 4'b0010;
  localparam logic [3:0] ETo   = 4'b0011;

  logic clk;
  logic rst_n;
  logic req_a, req_b, a, b, busy, timeout;
  logic req_a3, req_b3, a3, b3, busy3, timeout3;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] exp_q[$];
  logic       sel_q[$];
  string      name_q[$];

  mutex_grant_gen #(
    .MAX_HOLD(4),
    .GAP_CYC (1)
  ) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_a  (req_a),
    .req_b  (req_b),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .timeout(timeout)
  );

  mutex_grant_gen #(
    .MAX_HOLD(4),
    .GAP_CYC (3)
  ) u_dut_gap3 (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_a  (req_a3),
    .req_b  (req_b3),
    .a      (a3),
    .b      (b3),
    .busy   (busy3),
    .timeout(timeout3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [3:0] got, input logic [3:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: a/b/busy/timeout got %b expected %b at %0t", nm, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the post-edge expectation.
  task automatic step(input logic rst, input logic ra, input logic rb, input logic sel,
                      input logic [3:0] exp, input string nm);
    @(negedge clk);
    rst_n  = rst;
    req_a  = sel ? 1'b0 : ra;
    req_b  = sel ? 1'b0 : rb;
    req_a3 = sel ? ra : 1'b0;
    req_b3 = sel ? rb : 1'b0;
    exp_q.push_back(exp);
    sel_q.push_back(sel);
    name_q.push_back(nm);
  endtask

  // Monitor: compare every queued expectation against the selected instance.
  initial begin
    logic [3:0] e;
    logic       s;
    string      n;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        s = sel_q.pop_front();
        n = name_q.pop_front();
        if (s) check(n, {a3, b3, busy3, timeout3}, e);
        else   check(n, {a, b, busy, timeout}, e);
      end
    end
  end

  initial begin
    rst_n  = 1'b0;
    req_a  = 1'b0;
    req_b  = 1'b0;
    req_a3 = 1'b0;
    req_b3 = 1'b0;

    // Reset holds outputs low even with both requests high; then single grant and release.
    step(0, 1, 1, 0, EIdle, "reset_both_req");
    step(0, 1, 1, 0, EIdle, "reset_both_req");
    step(1, 1, 0, 0, EA,    "first_grant_a");
    step(1, 1, 0, 0, EA,    "hold_a");
    step(1, 0, 0, 0, EGap,  "release_a_gap");
    step(1, 0, 0, 0, EIdle, "gap_to_idle");

    // Both requesting from reset: A first, timeout, gap, B, timeout, gap, A.
    step(0, 0, 0, 0, EIdle, "reset2");
    for (int i = 0; i < 4; i++) step(1, 1, 1, 0, EA, "both_a");
    step(1, 1, 1, 0, ETo,   "both_to_a");
    for (int i = 0; i < 4; i++) step(1, 1, 1, 0, EB, "both_b");
    step(1, 1, 1, 0, ETo,   "both_to_b");
    step(1, 1, 1, 0, EA,    "both_a_again");
    step(1, 0, 0, 0, EGap,  "both_drop_gap");
    step(1, 0, 0, 0, EIdle, "both_drop_idle");

    // Only A requesting for 12 cycles: 4 on, 1 timeout gap, repeated.
    for (int i = 0; i < 12; i++) step(1, 1, 0, 0, (i % 5 == 4) ? ETo : EA, "a_only_regrant");
    step(1, 0, 0, 0, EGap,  "a_only_drop_gap");
    step(1, 0, 0, 0, EIdle, "a_only_idle");

    // Release on the same cycle the hold limit is reached: no timeout.
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, EA, "rel_at_max_hold");
    step(1, 0, 0, 0, EGap,  "rel_at_max_no_to");
    step(1, 0, 0, 0, EIdle, "rel_at_max_idle");

    // GAP_CYC=3 instance: B requested and toggled during the gap, granted 3 cycles after A falls.
    step(1, 1, 0, 1, EA,    "g3_grant_a");
    step(1, 0, 1, 1, EGap,  "g3_gap1");
    step(1, 0, 0, 1, EGap,  "g3_gap2_toggle");
    step(1, 0, 1, 1, EGap,  "g3_gap3");
    step(1, 0, 1, 1, EB,    "g3_grant_b");
    step(1, 0, 0, 1, EGap,  "g3_b_gap1");
    step(1, 0, 0, 1, EGap,  "g3_b_gap2");
    step(1, 0, 0, 1, EGap,  "g3_b_gap3");
    step(1, 0, 0, 1, EIdle, "g3_idle");

    // Asynchronous reset while B owns; A wins first after release.
    step(1, 0, 1, 0, EB,    "pre_rst_b");
    step(1, 0, 1, 0, EB,    "pre_rst_b_hold");
    step(0, 1, 1, 0, EIdle, "rst_during_b");
    #1;
    check("async_rst_drop", {a, b, busy, timeout}, EIdle);
    step(0, 1, 1, 0, EIdle, "rst_held");
    step(1, 1, 1, 0, EA,    "post_rst_a_first");
    step(1, 1, 1, 0, EA,    "post_rst_a_hold");
    step(1, 0, 0, 0, EGap,  "post_rst_gap");
    step(1, 0, 0, 0, EIdle, "post_rst_idle");

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
